pg_flr_event_serializer: RTL and testbench
==========================================

PG_FLR_EVENT_SERIALIZER -- requirements
Module: pg_flr_event_serializer

Interface
REQ-001 Parameter PG_NUM_PORTS, default 1, SHALL set the number of VF ports in the PR slot, legal range 1..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the HOLD-state watchdog limit in clk cycles, legal range 2..2^20.
REQ-003 clk  input  1  SHALL be the single clock; all flops run on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high; synchronous deassertion is the integrator's responsibility.
REQ-005 i_vf_rst_n  input  PG_NUM_PORTS  SHALL carry the per-port VF FLR reset, active-low, synchronous to clk.
REQ-006 o_flr_valid  output  1  SHALL indicate that an FLR event is offered.
REQ-007 o_flr_vf_num  output  7  SHALL carry the 1-based VF number of the event: port index + 1.
REQ-008 i_flr_ack  input  1  SHALL accept the offered event when sampled high together with o_flr_valid.
REQ-009 o_flr_active  output  1  SHALL be high while an accepted FLR is in progress.
REQ-010 o_pending  output  PG_NUM_PORTS  SHALL expose the pending-event bits.
REQ-011 o_merge_cnt  output  8  SHALL count merged (coalesced) events and saturate at 255.
REQ-012 o_timeout_err  output  1  SHALL be a sticky watchdog error flag.
REQ-013 i_err_clr  input  1  SHALL clear o_timeout_err and o_merge_cnt.

Function
REQ-014 The block SHALL register i_vf_rst_n and detect each 1->0 transition as an FLR assertion on that port.
REQ-015 An assertion SHALL set pending[p] on the following cycle.
REQ-016 An assertion on a port whose pending bit is already set SHALL leave the bit set and increment o_merge_cnt.
REQ-017 The FSM SHALL have four states: IDLE, SEND, HOLD, GAP.
REQ-018 IDLE: if any pending bit is set, the FSM SHALL latch the round-robin winner (search starts at last served index + 1, wraps at PG_NUM_PORTS), clear its pending bit, and go to SEND.
REQ-019 SEND: o_flr_valid SHALL be 1 and o_flr_vf_num SHALL be winner + 1, both stable until i_flr_ack; on ack the FSM SHALL go to HOLD.
REQ-020 HOLD: o_flr_active SHALL be 1; the FSM SHALL go to GAP when the registered i_vf_rst_n[winner] is 1, or when the watchdog reaches TIMEOUT_CYCLES-1, in which case o_timeout_err SHALL also be set.
REQ-021 GAP: exactly one cycle with all handshake outputs low, then IDLE.
REQ-022 Idle-to-valid latency SHALL be 1 cycle after pending is set; minimum event spacing SHALL be 4 cycles (IDLE, SEND with immediate ack, HOLD, GAP).
REQ-023 A new assertion on the winner's own port during SEND or HOLD SHALL set its pending bit, not retrigger the current event.
REQ-024 When i_err_clr coincides with a merge, the clear SHALL win and the counter SHALL read 0.
REQ-025 When i_err_clr coincides with a timeout, the error flag SHALL remain set.
REQ-026 The watchdog counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide, zero on HOLD entry, and count only in HOLD.

Reset
REQ-027 On reset the FSM SHALL be IDLE; pending, o_merge_cnt, watchdog and last-served index SHALL be 0.
REQ-028 On reset o_flr_valid, o_flr_active and o_timeout_err SHALL be 0, and o_flr_vf_num SHALL be 0.
REQ-029 On reset the registered i_vf_rst_n copy SHALL be all-ones, so ports held low at reset release register as one assertion each.
REQ-030 Reset asserted mid-event SHALL abort the event with no ack required.

Structure
REQ-031 The FSM state enum and the 7-bit VF-number width SHALL be defined in pg_flr_pkg.
REQ-032 The round-robin selector SHALL be one sub-module, pg_rr_arb (request vector plus last index in, one-hot grant plus index out), purely combinational.

Verification
REQ-033 Single event: drive port 2 low, ack on the first valid cycle, release 10 cycles later -> vf_num=3, active high for 11 cycles, one GAP cycle, then IDLE.
REQ-034 Simultaneous assertion of ports 0, 1, 3 with last served index 1 -> service order 3, 0, 1 (vf_num 4, 1, 2).
REQ-035 Port 0 pulses low twice while pending -> o_merge_cnt=1; 300 merges -> saturates at 255.
REQ-036 Ack withheld 50 cycles -> valid and vf_num stable for all 50 cycles, and HOLD is entered the cycle after ack.
REQ-037 TIMEOUT_CYCLES=16 with port never released -> o_timeout_err set after 16 HOLD cycles, then GAP; i_err_clr then clears the flag.
REQ-038 Reset asserted in HOLD -> all outputs return to their reset values asynchronously; after release, ports still low each produce one event.

Source files
------------

// File: rtl/pg_flr_pkg.sv
// Shared types and widths for the PR-slot FLR event serializer.
// Event state machine, VF-number width and the merge counter limits live here.
package pg_flr_pkg;

    localparam int VF_NUM_W    = 7;
    localparam int MERGE_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD,
        GAP
    } flr_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // VF numbers are 1-based: port index 0 is reported as VF 1
    function automatic logic [VF_NUM_W-1:0] vf_num_of(input int idx);
        return VF_NUM_W'(idx + 1);
    endfunction

endpackage

// File: rtl/pg_flr_event_serializer_if.sv
// Event offer/accept handshake between the serializer and the FLR consumer.
interface pg_flr_event_serializer_if;
    import pg_flr_pkg::*;

    logic                o_flr_valid;
    logic [VF_NUM_W-1:0] o_flr_vf_num;
    logic                i_flr_ack;
    logic                o_flr_active;

    modport master (
        output o_flr_valid,
        output o_flr_vf_num,
        output o_flr_active,
        input  i_flr_ack
    );

    modport slave (
        input  o_flr_valid,
        input  o_flr_vf_num,
        input  o_flr_active,
        output i_flr_ack
    );

endinterface

// File: rtl/pg_rr_arb.sv
// Combinational round-robin selector: the search starts one past the last
// served index and wraps at N; returns a one-hot grant and its index.
module pg_rr_arb #(
    parameter int N     = 1,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start;
    logic [N-1:0]     rotated;
    logic [IDX_W:0]   pos;
    logic             found;

    // Rotate the requests so the preferred port sits at bit 0, then take the
    // first set bit and map it back to an absolute port index.
    always_comb begin
        start   = (int'(last) >= N - 1) ? '0 : last + IDX_W'(1);
        rotated = N'({req, req} >> start);
        grant   = '0;
        idx     = '0;
        pos     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                pos   = {1'b0, start} + (IDX_W + 1)'(i);
                if (pos >= (IDX_W + 1)'(N)) begin
                    pos = pos - (IDX_W + 1)'(N);
                end
                idx   = pos[IDX_W-1:0];
                grant = N'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/pg_flr_event_serializer.sv
// Turns per-port VF FLR assertions into a serialized stream of FLR events,
// one at a time, with coalescing, round-robin fairness and a HOLD watchdog.
module pg_flr_event_serializer
    import pg_flr_pkg::*;
#(
    parameter int PG_NUM_PORTS   = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PG_NUM_PORTS-1:0] i_vf_rst_n,
    input  logic                    i_err_clr,
    output logic [PG_NUM_PORTS-1:0] o_pending,
    output logic [MERGE_CNT_W-1:0]  o_merge_cnt,
    output logic                    o_timeout_err,
    pg_flr_event_serializer_if.master flr
);

    localparam int IDX_W = idx_width(PG_NUM_PORTS);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    flr_state_e              state;
    logic [PG_NUM_PORTS-1:0] vf_q;
    logic [PG_NUM_PORTS-1:0] fall;
    logic [PG_NUM_PORTS-1:0] merge;
    logic [PG_NUM_PORTS-1:0] clear_mask;
    logic [PG_NUM_PORTS-1:0] grant;
    logic [PG_NUM_PORTS-1:0] winner_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        last_idx;
    logic [WD_W-1:0]         wd;
    logic [6:0]              merge_add;
    logic [MERGE_CNT_W:0]    merge_sum;
    logic                    take;

    pg_rr_arb #(
        .N     (PG_NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (o_pending),
        .last  (last_idx),
        .grant (grant),
        .idx   (grant_idx)
    );

    // A bit cleared by the arbiter in the same cycle it re-asserts is a fresh
    // event rather than a merge, so it is excluded from the merge count.
    always_comb begin
        fall       = vf_q & ~i_vf_rst_n;
        take       = (state == IDLE) && (|o_pending);
        clear_mask = take ? grant : '0;
        merge      = fall & o_pending & ~clear_mask;
        merge_add  = '0;
        for (int i = 0; i < PG_NUM_PORTS; i++) begin
            merge_add = merge_add + {6'b0, merge[i]};
        end
        merge_sum = {1'b0, o_merge_cnt} + {2'b0, merge_add};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vf_q        <= '1;
            o_pending   <= '0;
            o_merge_cnt <= '0;
        end else begin
            vf_q      <= i_vf_rst_n;
            o_pending <= (o_pending & ~clear_mask) | fall;
            if (i_err_clr) begin
                o_merge_cnt <= '0;
            end else if (merge_sum[MERGE_CNT_W]) begin
                o_merge_cnt <= '1;
            end else begin
                o_merge_cnt <= merge_sum[MERGE_CNT_W-1:0];
            end
        end
    end

    // The timeout assignment follows the clear so a coincident timeout wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            winner_oh         <= '0;
            last_idx          <= '0;
            wd                <= '0;
            flr.o_flr_valid   <= 1'b0;
            flr.o_flr_vf_num  <= '0;
            flr.o_flr_active  <= 1'b0;
            o_timeout_err     <= 1'b0;
        end else begin
            if (i_err_clr) begin
                o_timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        winner_oh        <= grant;
                        last_idx         <= grant_idx;
                        flr.o_flr_vf_num <= vf_num_of(int'(grant_idx));
                        flr.o_flr_valid  <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    if (flr.i_flr_ack) begin
                        flr.o_flr_valid  <= 1'b0;
                        flr.o_flr_active <= 1'b1;
                        wd               <= '0;
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    if (|(vf_q & winner_oh)) begin
                        flr.o_flr_active <= 1'b0;
                        flr.o_flr_vf_num <= '0;
                        state            <= GAP;
                    end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        o_timeout_err    <= 1'b1;
                        flr.o_flr_active <= 1'b0;
                        flr.o_flr_vf_num <= '0;
                        state            <= GAP;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pg_flr_event_serializer.sv
// Scoreboard bench: stimulus queues the expected VF numbers, a monitor pops
// them at each accepted offer and watches SEND stability, HOLD entry and GAP.
module tb_pg_flr_event_serializer;
    import pg_flr_pkg::*;

    localparam int NP = 4;
    localparam int TO = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NP-1:0]          vf_rst_n;
    logic                   err_clr;
    logic [NP-1:0]          pending;
    logic [MERGE_CNT_W-1:0] merge_cnt;
    logic                   timeout_err;

    pg_flr_event_serializer_if flr_bus ();

    pg_flr_event_serializer #(
        .PG_NUM_PORTS   (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_vf_rst_n    (vf_rst_n),
        .i_err_clr     (err_clr),
        .o_pending     (pending),
        .o_merge_cnt   (merge_cnt),
        .o_timeout_err (timeout_err),
        .flr           (flr_bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [VF_NUM_W-1:0] exp_q[$];

    int ack_wait        = 0;
    int ack_waited      = 0;
    int last_active_len = 0;
    int last_valid_len  = 0;
    int active_run      = 0;
    int valid_run       = 0;
    logic                prev_valid = 1'b0;
    logic                prev_hs    = 1'b0;
    logic [VF_NUM_W-1:0] prev_vf    = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle low pulse on the masked ports, then one cycle high again.
    task automatic applyStimulus(input logic [NP-1:0] mask);
        vf_rst_n = vf_rst_n & ~mask;
        waitCycles(1);
        vf_rst_n = vf_rst_n | mask;
        waitCycles(1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput("queue_drained", exp_q.size(), 0);
    endtask

    task automatic waitActive(input logic level, input int budget);
        int n = 0;
        while (flr_bus.o_flr_active !== level && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput("wait_active", flr_bus.o_flr_active, level);
    endtask

    // Consumer: accept after ack_wait valid cycles have gone by unanswered.
    initial begin
        flr_bus.i_flr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !flr_bus.o_flr_valid) begin
                flr_bus.i_flr_ack = 1'b0;
                ack_waited        = 0;
            end else if (ack_waited >= ack_wait) begin
                flr_bus.i_flr_ack = 1'b1;
            end else begin
                ack_waited++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            active_run = 0;
            valid_run  = 0;
        end else begin
            if (prev_hs) begin
                checkOutput("hold_entry_active", flr_bus.o_flr_active, 1);
                checkOutput("hold_entry_valid", flr_bus.o_flr_valid, 0);
            end else if (prev_valid) begin
                checkOutput("send_valid_stable", flr_bus.o_flr_valid, 1);
                checkOutput("send_vf_stable", flr_bus.o_flr_vf_num, prev_vf);
            end
            if (flr_bus.o_flr_valid && flr_bus.i_flr_ack) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_event: got vf %0d, expected none",
                             flr_bus.o_flr_vf_num);
                end else begin
                    checkOutput("event_vf_num", flr_bus.o_flr_vf_num, exp_q.pop_front());
                end
            end
            if (flr_bus.o_flr_valid) begin
                valid_run++;
            end else if (valid_run > 0) begin
                last_valid_len = valid_run;
                valid_run      = 0;
            end
            if (flr_bus.o_flr_active) begin
                active_run++;
            end else if (active_run > 0) begin
                last_active_len = active_run;
                active_run      = 0;
                checkOutput("gap_valid", flr_bus.o_flr_valid, 0);
                checkOutput("gap_vf_num", flr_bus.o_flr_vf_num, 0);
            end
            prev_valid = flr_bus.o_flr_valid;
            prev_vf    = flr_bus.o_flr_vf_num;
            prev_hs    = flr_bus.o_flr_valid && flr_bus.i_flr_ack;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset    = 1'b1;
        vf_rst_n = '1;
        err_clr  = 1'b0;
        waitCycles(3);
        checkOutput("rst_valid", flr_bus.o_flr_valid, 0);
        checkOutput("rst_vf_num", flr_bus.o_flr_vf_num, 0);
        checkOutput("rst_active", flr_bus.o_flr_active, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_merge", merge_cnt, 0);
        checkOutput("rst_err", timeout_err, 0);
        reset = 1'b0;
        waitCycles(3);
        checkOutput("idle_valid", flr_bus.o_flr_valid, 0);

        // Single event on port 2, released 10 cycles after the offer appears
        vf_rst_n[2] = 1'b0;
        exp_q.push_back(7'd3);
        waitCycles(1);
        checkOutput("pending_set", pending, 4'b0100);
        checkOutput("latency_valid_low", flr_bus.o_flr_valid, 0);
        waitCycles(1);
        checkOutput("latency_valid_high", flr_bus.o_flr_valid, 1);
        checkOutput("pending_cleared", pending, 0);
        waitCycles(10);
        vf_rst_n[2] = 1'b1;
        waitCycles(4);
        checkOutput("single_active_len", last_active_len, 11);
        checkOutput("single_valid_len", last_valid_len, 1);
        checkOutput("single_drained", exp_q.size(), 0);

        // Serve port 1 so the next round-robin search starts at port 2
        exp_q.push_back(7'd2);
        applyStimulus(4'b0010);
        waitDrain(50);
        waitCycles(6);

        exp_q.push_back(7'd4);
        exp_q.push_back(7'd1);
        exp_q.push_back(7'd2);
        applyStimulus(4'b1011);
        waitDrain(100);
        waitCycles(6);

        // Merges: port 3 stalls in SEND while port 0 keeps re-asserting
        checkOutput("merge_start", merge_cnt, 0);
        ack_wait = 100000;
        exp_q.push_back(7'd4);
        applyStimulus(4'b1000);
        waitCycles(2);
        exp_q.push_back(7'd1);
        applyStimulus(4'b0001);
        checkOutput("merge_first_pulse", merge_cnt, 0);
        checkOutput("merge_pending", pending, 4'b0001);
        applyStimulus(4'b0001);
        checkOutput("merge_one", merge_cnt, 1);
        repeat (300) applyStimulus(4'b0001);
        checkOutput("merge_saturate", merge_cnt, 255);
        err_clr     = 1'b1;
        vf_rst_n[0] = 1'b0;
        waitCycles(1);
        err_clr     = 1'b0;
        vf_rst_n[0] = 1'b1;
        checkOutput("merge_clear_wins", merge_cnt, 0);
        checkOutput("merge_still_pending", pending, 4'b0001);
        waitCycles(1);
        ack_wait = 0;
        waitDrain(60);
        waitCycles(8);

        // Ack withheld for 50 valid cycles
        ack_wait = 50;
        exp_q.push_back(7'd3);
        applyStimulus(4'b0100);
        waitDrain(200);
        ack_wait = 0;
        waitCycles(6);
        checkOutput("withheld_valid_len", last_valid_len, 51);

        // Port 1 never released: watchdog expires after 16 HOLD cycles
        exp_q.push_back(7'd2);
        vf_rst_n[1] = 1'b0;
        waitActive(1'b1, 20);
        waitActive(1'b0, 40);
        waitCycles(1);
        checkOutput("timeout_active_len", last_active_len, TO);
        checkOutput("timeout_err_set", timeout_err, 1);
        err_clr = 1'b1;
        waitCycles(1);
        err_clr = 1'b0;
        checkOutput("timeout_err_cleared", timeout_err, 0);

        // Clear presented on the very edge the watchdog fires
        vf_rst_n[1] = 1'b1;
        waitCycles(2);
        exp_q.push_back(7'd2);
        vf_rst_n[1] = 1'b0;
        waitActive(1'b1, 20);
        repeat (TO - 1) @(posedge clk);
        #1;
        err_clr = 1'b1;
        waitCycles(1);
        err_clr = 1'b0;
        checkOutput("timeout_beats_clear", timeout_err, 1);
        checkOutput("timeout_exit_active", flr_bus.o_flr_active, 0);
        vf_rst_n[1] = 1'b1;
        waitCycles(4);

        // Reset during HOLD, with ports 0 and 2 still low across the release
        exp_q.push_back(7'd3);
        vf_rst_n = 4'b1010;
        waitActive(1'b1, 20);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_valid", flr_bus.o_flr_valid, 0);
        checkOutput("async_rst_vf_num", flr_bus.o_flr_vf_num, 0);
        checkOutput("async_rst_active", flr_bus.o_flr_active, 0);
        checkOutput("async_rst_pending", pending, 0);
        checkOutput("async_rst_merge", merge_cnt, 0);
        checkOutput("async_rst_err", timeout_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(7'd3);
        exp_q.push_back(7'd1);
        waitDrain(150);
        waitActive(1'b0, 40);
        vf_rst_n = '1;
        waitCycles(5);
        checkOutput("post_rst_err", timeout_err, 1);
        checkOutput("post_rst_pending", pending, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
